// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: op codes, alu_status codes and FSM states shared by the mul/div sequencer, hazard control and EX decode
package muldiv_sequencer_pkg;
  localparam logic [1:0] MD_OP_MUL  = 2'b00;
  localparam logic [1:0] MD_OP_MULH = 2'b01;
  localparam logic [1:0] MD_OP_DIVU = 2'b10;
  localparam logic [1:0] MD_OP_REMU = 2'b11;
  localparam logic [1:0] ALU_ST_IDLE      = 2'b00;
  localparam logic [1:0] ALU_ST_DONE      = 2'b01;
  localparam logic [1:0] ALU_ST_BUSY      = 2'b10;
  localparam logic [1:0] ALU_ST_BUSY_LAST = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add multiply or restoring divide iteration; acc={hi,lo}, operand=multiplicand or divisor, nxt=acc after the step
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] nxt
);
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH:0] sum, trial;
  logic ge;
  always_comb begin
    hi = acc[2*WIDTH-1:WIDTH];
    lo = acc[WIDTH-1:0];
    sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    trial = {hi, lo[WIDTH-1]};
    ge = trial >= {1'b0, operand};
    nxt = is_div ? (ge ? {WIDTH'(trial - {1'b0, operand}), lo[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0})
                 : {sum, lo[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the iterative EX-stage multiply/divide unit and drives alu_status for hazard control
// ports: clk, rst (sync, active high), start/op/src_a/src_b issue, flush kill; result/result_valid, alu_status, busy out
module muldiv_sequencer import muldiv_sequencer_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [1:0]       alu_status,
  output logic             busy
);
  state_t state;
  logic [CNT_W-1:0] count;
  logic [2*WIDTH-1:0] acc, nxt;
  logic [WIDTH-1:0] operand, fin;
  logic [1:0] op_q;
  logic dz, zero_div, last;
  muldiv_step #(.WIDTH(WIDTH)) u_step (.is_div(op_q[1]), .acc(acc), .operand(operand), .nxt(nxt));
  assign zero_div = op[1] && src_b == '0;
  assign last = count == CNT_W'(1);
  // divide by zero skips iterating: acc still holds the dividend in its low half
  assign fin = dz ? (op_q == MD_OP_DIVU ? '1 : acc[WIDTH-1:0])
                  : (op_q == MD_OP_MUL || op_q == MD_OP_DIVU) ? nxt[WIDTH-1:0] : nxt[2*WIDTH-1:WIDTH];
  assign result_valid = state == ST_DONE;
  assign busy = state == ST_RUN;
  assign alu_status = state == ST_RUN ? (last ? ALU_ST_BUSY_LAST : ALU_ST_BUSY)
                    : state == ST_DONE ? ALU_ST_DONE : ALU_ST_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      acc <= '0;
      operand <= '0;
      op_q <= MD_OP_MUL;
      dz <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      count <= '0;
    end else if (state == ST_RUN) begin
      acc <= nxt;
      count <= count - CNT_W'(1);
      if (last) begin
        state <= ST_DONE;
        result <= fin;
      end
    end else if (start) begin
      state <= ST_RUN;
      op_q <= op;
      operand <= op[1] ? src_b : src_a;
      acc <= {{WIDTH{1'b0}}, op[1] ? src_a : src_b};
      dz <= zero_div;
      count <= zero_div ? CNT_W'(1) : CNT_W'(WIDTH);
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer results, latency, status sequence, flush and reset
module tb_muldiv_sequencer;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst, start, flush;
  logic [1:0] op;
  logic [W-1:0] a, b, result;
  logic result_valid, busy;
  logic [1:0] alu_status;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {logic [W-1:0] res; int at;} exp_t;
  exp_t sbq[$];

  muldiv_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(a), .src_b(b), .flush(flush),
    .result(result), .result_valid(result_valid), .alu_status(alu_status), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] model(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      2'b00: return p[W-1:0];
      2'b01: return p[2*W-1:W];
      2'b10: return y == '0 ? '1 : x / y;
      default: return y == '0 ? x : x % y;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (result_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got result=%h with nothing pending at cycle %0d", result, cyc);
      end else begin
        e = sbq.pop_front();
        n_cmp += 2;
        if (result !== e.res) begin
          n_err++;
          $display("FAIL result_value: got %h expected %h", result, e.res);
        end
        if (cyc !== e.at) begin
          n_err++;
          $display("FAIL result_latency: valid at cycle %0d expected %0d", cyc, e.at);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    sbq.push_back('{model(o, x, y), cyc + ((o[1] && y == '0) ? 2 : W + 1)});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && (sbq.size() != 0 || busy); i++) @(negedge clk);
    n_cmp++;
    if (sbq.size() != 0 || busy) begin
      n_err++;
      $display("FAIL drain_timeout: pending=%0d busy=%b expected pending=0 busy=0", sbq.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp += 4;
    if (result !== '0) begin n_err++; $display("FAIL reset_result: got %h expected 0", result); end
    if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    if (alu_status !== 2'b00) begin n_err++; $display("FAIL reset_status: got %b expected 00", alu_status); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [1:0] exp_st;
    issue(2'b00, 16'h00FF, 16'h0101);
    wait_drain();
    issue(2'b01, 16'h00FF, 16'h0101);
    wait_drain();
    issue(2'b01, 16'hFFFF, 16'hFFFF);
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      exp_st = i <= 15 ? 2'b10 : i == 16 ? 2'b11 : i == 17 ? 2'b01 : 2'b00;
      n_cmp++;
      if (alu_status !== exp_st) begin
        n_err++;
        $display("FAIL status_seq[%0d]: got %b expected %b", i, alu_status, exp_st);
      end
    end
    issue(2'b00, 16'hFFFF, 16'hFFFF);
    wait_drain();
    issue(2'b00, 16'h1234, 16'h5678);
    wait_drain();
  endtask

  task automatic test_div();
    issue(2'b10, 16'd1000, 16'd7);
    start = 1'b1;
    op = 2'b00;
    a = 16'd3;
    b = 16'd5;
    repeat (10) @(posedge clk);
    #1 start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL div_busy_hold: got %b expected 1", busy); end
    wait_drain();
    issue(2'b11, 16'd1000, 16'd7);
    wait_drain();
    issue(2'b10, 16'hFFFF, 16'h0003);
    wait_drain();
  endtask

  task automatic test_divzero();
    issue(2'b10, 16'h1234, 16'h0000);
    @(negedge clk);
    n_cmp += 2;
    if (alu_status !== 2'b11) begin n_err++; $display("FAIL divzero_status: got %b expected 11", alu_status); end
    if (busy !== 1'b1) begin n_err++; $display("FAIL divzero_busy: got %b expected 1", busy); end
    wait_drain();
    issue(2'b11, 16'h1234, 16'h0000);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 16'h1234, 16'h0003);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) break;
    end
    n_cmp++;
    if (result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first_done: result_valid=%b expected 1", result_valid);
    end
    issue(2'b10, 16'hFFFF, 16'h0010);
    wait_drain();
  endtask

  task automatic test_kill(input bit use_rst);
    exp_t dropped;
    issue(2'b00, 16'h00FF, 16'h0101);
    repeat (7) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    start = 1'b1;
    op = 2'b10;
    a = 16'd5;
    b = 16'd1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    dropped = sbq.pop_back();
    @(negedge clk);
    n_cmp += 3;
    if (alu_status !== 2'b00) begin n_err++; $display("FAIL kill%0d_status: got %b expected 00", use_rst, alu_status); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL kill%0d_busy: got %b expected 0", use_rst, busy); end
    if (result_valid !== 1'b0) begin n_err++; $display("FAIL kill%0d_valid: got %b expected 0", use_rst, result_valid); end
    if (use_rst) begin
      n_cmp++;
      if (result !== '0) begin n_err++; $display("FAIL kill_rst_result: got %h expected 0", result); end
    end
    repeat (20) @(posedge clk);
    #1;
    issue(2'b11, dropped.res, 16'd10);
    wait_drain();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    test_reset();
    test_mul();
    test_div();
    test_divzero();
    test_back_to_back();
    test_kill(1'b0);
    test_kill(1'b1);
    repeat (30) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
